// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline fetch stage
//
// Contents:
//   NOP_INST         instruction word loaded into IF/ID when it holds nothing
//   PCS_*            pcsource encodings (seq, branch, register, jump)
//   fetch_state_t    fetch FSM states
//   fetch_entry_t    one fetch-queue entry {inst, pc4}
//   redirect_target  selects bpc/rpc/jpc from pcsource
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [1:0] PCS_SEQ = 2'd0;
  localparam logic [1:0] PCS_BR  = 2'd1;
  localparam logic [1:0] PCS_JR  = 2'd2;
  localparam logic [1:0] PCS_J   = 2'd3;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } fetch_entry_t;

  function automatic logic [31:0] redirect_target(
    input logic [1:0]  pcs,
    input logic [31:0] br_pc,
    input logic [31:0] jr_pc,
    input logic [31:0] j_pc
  );
    case (pcs)
      PCS_BR:  return br_pc;
      PCS_JR:  return jr_pc;
      PCS_J:   return j_pc;
      default: return j_pc;
    endcase
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {inst, pc4} entries
//
// Ports:
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   flush      empty the queue; wins over push and pop
//   head       current head entry (undefined while empty)
//   count      number of valid entries, 0..DEPTH
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pipe_fetch_unit.sv
// rtl/pipe_fetch_unit.sv - instruction-fetch stage feeding the IF/ID register
//
// Owns the fetch PC, runs a req/ack handshake to a variable-latency instruction
// memory, buffers words in fetch_queue and drives IF/ID. A taken redirect
// squashes all younger fetches (no delay slot).
//
// Optional build macro FETCH_BYPASS_EN: a word acked while the queue is empty
// and ID is accepting goes straight into IF/ID, saving one cycle.
//
// Ports:
//   clock, resetn            clock, asynchronous active-low reset
//   imem_req/addr            fetch request and word address (stable while req)
//   imem_ack/rdata           one-cycle ack pulse with the instruction word
//   wpcir                    1 = ID accepts a new instruction, 0 = hold IF/ID
//   pcsource, bpc, rpc, jpc  redirect select and targets
//   id_inst/id_pc4/id_valid  IF/ID register
module pipe_fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  state, state_next;
  logic [31:0]   fpc, fpc_next;
  logic [31:0]   req_addr, req_addr_next;
  logic          redirect;
  logic [31:0]   target;
  logic          credit_ok;
  logic          ack_keep;
  logic          bypass;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic [CW-1:0] q_count;

  assign redirect = id_valid && wpcir && (pcsource != PCS_SEQ);
  assign target   = redirect_target(pcsource, bpc, rpc, jpc);

  // At most one request is ever in flight and issue only happens from IDLE,
  // where nothing is outstanding, so a free queue slot is the whole credit.
  assign credit_ok = q_count < CW'(QUEUE_DEPTH);
  assign q_empty   = (q_count == '0);

  assign imem_req  = (state != FS_IDLE);
  assign imem_addr = req_addr;

  assign ack_keep  = (state == FS_WAIT) && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = ack_keep && wpcir && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign q_push      = ack_keep && !bypass;
  assign q_pop       = wpcir && !redirect && !q_empty;
  assign q_push_data = '{inst: imem_rdata, pc4: req_addr + 32'd4};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .resetn    (resetn),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (q_count)
  );

  always_comb begin
    state_next    = state;
    fpc_next      = fpc;
    req_addr_next = req_addr;
    case (state)
      FS_IDLE: begin
        if (!redirect && credit_ok) begin
          req_addr_next = fpc;
          fpc_next      = fpc + 32'd4;
          state_next    = FS_WAIT;
        end
      end
      FS_WAIT: begin
        // An ack always closes the request; whether the word is kept is
        // decided by ack_keep. Without an ack, a redirect orphans it.
        if (imem_ack)      state_next = FS_IDLE;
        else if (redirect) state_next = FS_DISCARD;
      end
      FS_DISCARD: begin
        if (imem_ack) state_next = FS_IDLE;
      end
      default: state_next = FS_IDLE;
    endcase
    if (redirect) fpc_next = target;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= FS_IDLE;
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fpc      <= fpc_next;
      req_addr <= req_addr_next;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      id_inst  <= NOP_INST;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (redirect) begin
      id_inst  <= NOP_INST;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (wpcir) begin
      if (bypass) begin
        id_inst  <= imem_rdata;
        id_pc4   <= req_addr + 32'd4;
        id_valid <= 1'b1;
      end else if (!q_empty) begin
        id_inst  <= q_head.inst;
        id_pc4   <= q_head.pc4;
        id_valid <= 1'b1;
      end else begin
        id_inst  <= NOP_INST;
        id_pc4   <= '0;
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// tb/tb_pipe_fetch_unit.sv - scoreboard bench for pipe_fetch_unit
module tb_pipe_fetch_unit;
  import pipe_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int LAT_EXP = 1;
`else
  localparam int LAT_EXP = 2;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic [31:0] id_inst, id_pc4;
  logic        id_valid;

  int total = 0;
  int bad   = 0;
  int acc   = 0;
  int cyc   = 0;
  int budget = 0;
  int lat    = 0;
  int cnt    = 0;
  int first_ack   = -1;
  int first_valid = -1;
  bit found;

  fetch_entry_t exp_q[$];
  logic [31:0]  addr_log[$];

  pipe_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .id_inst    (id_inst),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] inst, input logic [31:0] pc4);
    exp_q.push_back('{inst: inst, pc4: pc4});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_acc(input int n, input string name);
    int k;
    k = 0;
    while (acc < n && k < 400) begin
      @(posedge clock);
      k++;
    end
    check(name, acc, n);
  endtask

  // Memory model: word = address ^ 8C00_0000, acks after lat waiting cycles,
  // and only while budget remains.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clock);
      #2;
      imem_ack = 1'b0;
      if (!imem_req) begin
        cnt = 0;
      end else if (cnt >= lat && budget > 0) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ 32'h8C00_0000;
        budget--;
        addr_log.push_back(imem_addr);
        if (first_ack < 0) first_ack = cyc;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: every cycle ID accepts a valid instruction it must match the scoreboard head.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clock);
      if (resetn && id_valid && wpcir) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_id: got pc4 %h want none", id_pc4);
        end else begin
          e = exp_q.pop_front();
          check("id_inst", id_inst, e.inst);
          check("id_pc4", id_pc4, e.pc4);
        end
        acc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; wpcir = 1'b1; pcsource = PCS_SEQ;
    bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
    lat = 1; budget = 0;
    repeat (3) step();
    check("rst_req", imem_req, 0);
    check("rst_valid", id_valid, 0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_pc4", id_pc4, 32'h0);

    // Sequential fetch, memory acks one cycle after req.
    exp_push(32'h8C00_0000, 32'h04);
    exp_push(32'h8C00_0004, 32'h08);
    exp_push(32'h8C00_0008, 32'h0C);
    exp_push(32'h8C00_000C, 32'h10);
    exp_push(32'h8C00_0010, 32'h14);
    exp_push(32'h8C00_0014, 32'h18);
    budget = 6;
    resetn = 1'b1;
    wait_acc(6, "p1_count");
    check("p1_latency", first_valid - first_ack, LAT_EXP);
    check("p1_addr0", addr_log[0], 32'h0);
    check("p1_addr5", addr_log[5], 32'h14);

    // Hold ID with words queued; fetch must stop on credits.
    step();
    lat = 0;
    exp_push(32'h8C00_0018, 32'h1C);
    exp_push(32'h8C00_001C, 32'h20);
    exp_push(32'h8C00_0020, 32'h24);
    exp_push(32'h8C00_0024, 32'h28);
    budget = 4;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (id_valid && id_pc4 == 32'h1C) begin
        wpcir = 1'b0;
        found = 1;
        break;
      end
    end
    check("p2_found", found, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("p2_hold_pc4", id_pc4, 32'h1C);
    end
    check("p2_hold_valid", id_valid, 1);
    check("p2_hold_inst", id_inst, 32'h8C00_0018);
    check("p2_req_off", imem_req, 0);
    wpcir = 1'b1;
    wait_acc(10, "p2_count");

    // Branch redirect while a request is outstanding -> DISCARD.
    exp_push(32'h8C00_0028, 32'h2C);
    exp_push(32'h8C00_0100, 32'h104);
    exp_push(32'h8C00_0104, 32'h108);
    budget = 1;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (id_valid && id_pc4 == 32'h2C) begin
        if (imem_req && imem_addr == 32'h2C) begin
          wpcir = 1'b1; pcsource = PCS_BR; bpc = 32'h100;
          found = 1;
          break;
        end else begin
          wpcir = 1'b0;
        end
      end
    end
    check("p3_found", found, 1);
    step();
    pcsource = PCS_SEQ;
    check("p3_nop_valid", id_valid, 0);
    check("p3_nop_inst", id_inst, 32'h0);
    check("p3_discard_req", imem_req, 1);
    check("p3_discard_addr", imem_addr, 32'h2C);
    step();
    check("p3_discard_hold", imem_addr, 32'h2C);
    budget = 3;
    wait_acc(13, "p3_count");
    check("p3_target_addr", addr_log[12], 32'h100);

    // Ack and jump redirect in the same cycle.
    exp_push(32'h8C00_0108, 32'h10C);
    exp_push(32'h8C00_2000, 32'h2004);
    exp_push(32'h8C00_2004, 32'h2008);
    budget = 1;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (id_valid && id_pc4 == 32'h10C) begin
        if (imem_req && imem_addr == 32'h10C && budget == 0) begin
          wpcir = 1'b1; pcsource = PCS_J; jpc = 32'h2000; budget = 1;
          found = 1;
          break;
        end else begin
          wpcir = 1'b0;
        end
      end
    end
    check("p4_found", found, 1);
    step();
    pcsource = PCS_SEQ;
    check("p4_idle_req", imem_req, 0);
    check("p4_nop_valid", id_valid, 0);
    step();
    check("p4_next_addr", imem_addr, 32'h2000);
    budget = 2;
    wait_acc(16, "p4_count");
    check("p4_dropped_addr", addr_log[15], 32'h10C);

    // Reset in the middle of an outstanding request.
    step();
    check("p5_pre_req", imem_req, 1);
    resetn = 1'b0;
    #1;
    check("p5_rst_req", imem_req, 0);
    check("p5_rst_valid", id_valid, 0);
    check("p5_sb_empty", exp_q.size(), 0);
    step();
    step();
    exp_push(32'h8C00_0000, 32'h04);
    exp_push(32'h8C00_0004, 32'h08);
    budget = 2;
    resetn = 1'b1;
    wait_acc(18, "p5_count");
    check("p5_first_addr", addr_log[18], 32'h0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
